// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned SCAN_DIV_DEFAULT        = 50000;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Indexed by {row, col}; entry 0 is row 0 / column 0.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [1:0] lowest_row(input logic [3:0] low);
    if (low[0]) return 2'd0;
    if (low[1]) return 2'd1;
    if (low[2]) return 2'd2;
    return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous multi-bit level inputs.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and a two-digit history.
// Macro KEYPAD_DEBOUNCE_EN enables DEBOUNCE_CYCLES-long debounce; otherwise one cycle each.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = SCAN_DIV_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [3:0] left_digit,
  output logic [3:0] right_digit
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
`ifdef KEYPAD_DEBOUNCE_EN
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
`else
  localparam logic [DB_W-1:0] DB_LAST = '0;
`endif

  state_t            state, state_next;
  logic [1:0]        col_idx, col_idx_next;
  logic [3:0]        col_n_next;
  logic [1:0]        row_sel, row_sel_next;
  logic [SCAN_W-1:0] scan_cnt, scan_cnt_next;
  logic [DB_W-1:0]   db_cnt, db_cnt_next;
  logic [3:0]        key_code_next, left_next, right_next;
  logic              key_valid_next, key_held_next;
  logic [3:0]        rows_sync;
  logic              cap_row_high;
  logic              advance;

  sync_2ff #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row_n),
    .q     (rows_sync)
  );

  assign cap_row_high = rows_sync[row_sel];

  // Next-state and output decode
  always_comb begin
    state_next     = state;
    col_idx_next   = col_idx;
    col_n_next     = col_n;
    row_sel_next   = row_sel;
    scan_cnt_next  = scan_cnt;
    db_cnt_next    = db_cnt;
    key_code_next  = key_code;
    left_next      = left_digit;
    right_next     = right_digit;
    key_valid_next = 1'b0;
    advance        = 1'b0;

    case (state)
      SCAN: begin
        if (scan_cnt == SCAN_LAST) begin
          scan_cnt_next = '0;
          if (rows_sync != 4'hF) begin
            row_sel_next = lowest_row(~rows_sync);
            db_cnt_next  = '0;
            state_next   = DEBOUNCE;
          end else begin
            advance = 1'b1;
          end
        end else begin
          scan_cnt_next = scan_cnt + SCAN_W'(1);
        end
      end
      DEBOUNCE: begin
        if (cap_row_high) begin
          advance    = 1'b1;
          state_next = SCAN;
        end else if (db_cnt == DB_LAST) begin
          key_valid_next = 1'b1;
          key_code_next  = KEY_MAP[{row_sel, col_idx}];
          left_next      = right_digit;
          right_next     = KEY_MAP[{row_sel, col_idx}];
          state_next     = HELD;
        end else begin
          db_cnt_next = db_cnt + DB_W'(1);
        end
      end
      HELD: begin
        if (cap_row_high) begin
          db_cnt_next = '0;
          state_next  = RELEASE;
        end
      end
      RELEASE: begin
        if (!cap_row_high) begin
          state_next = HELD;
        end else if (db_cnt == DB_LAST) begin
          advance    = 1'b1;
          state_next = SCAN;
        end else begin
          db_cnt_next = db_cnt + DB_W'(1);
        end
      end
      default: state_next = SCAN;
    endcase

    if (advance) begin
      col_idx_next = col_idx + 2'd1;
      col_n_next   = {col_n[2:0], col_n[3]};
    end

    key_held_next = (state_next == HELD) || (state_next == RELEASE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SCAN;
      col_idx     <= 2'd0;
      col_n       <= 4'b1110;
      row_sel     <= 2'd0;
      scan_cnt    <= '0;
      db_cnt      <= '0;
      key_code    <= 4'h0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
      left_digit  <= 4'h0;
      right_digit <= 4'h0;
    end else begin
      state       <= state_next;
      col_idx     <= col_idx_next;
      col_n       <= col_n_next;
      row_sel     <= row_sel_next;
      scan_cnt    <= scan_cnt_next;
      db_cnt      <= db_cnt_next;
      key_code    <= key_code_next;
      key_valid   <= key_valid_next;
      key_held    <= key_held_next;
      left_digit  <= left_next;
      right_digit <= right_next;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner; a behavioural keypad pulls rows low from the driven column.
module tb_keypad_scanner;

`ifdef KEYPAD_DEBOUNCE_EN
  localparam int DB          = 8;
  localparam int GLITCH      = 3;
  localparam int BOUNCE      = 2;
  localparam int SHORT_PRESS = 20;
`else
  localparam int DB          = 1;
  localparam int GLITCH      = 1;
  localparam int BOUNCE      = 1;
  localparam int SHORT_PRESS = 3;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [3:0] left_digit;
  logic [3:0] right_digit;

  logic       pressed = 1'b0;
  logic [1:0] press_row = 2'd0;
  logic [1:0] press_col = 2'd0;
  logic [3:0] glitch_mask = 4'h0;

  int vectors = 0;
  int miscompares = 0;
  int valid_count = 0;

  assign row_n = ~(glitch_mask |
                   ((pressed && !col_n[press_col]) ? (4'b0001 << press_row) : 4'h0));

  keypad_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .row_n       (row_n),
    .col_n       (col_n),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .left_digit  (left_digit),
    .right_digit (right_digit)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (key_valid === 1'b1) valid_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c);
    press_row = r;
    press_col = c;
    pressed   = 1'b1;
  endtask

  task automatic wait_count(input int target, input int budget);
    int n = 0;
    while (valid_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_release(input int budget);
    int n = 0;
    while (key_held !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    logic [3:0] exp_col;
    int pre;

    // Reset state while reset is held
    repeat (2) @(negedge clk);
    check("rst_col_n", 32'(col_n), 32'(4'b1110));
    check("rst_key_code", 32'(key_code), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_key_held", 32'(key_held), 32'h0);
    check("rst_left", 32'(left_digit), 32'h0);
    check("rst_right", 32'(right_digit), 32'h0);
    reset = 1'b0;

    // Idle scan: each column driven for 4 cycles
    for (int k = 0; k < 40; k++) begin
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check("scan_col_n", 32'(col_n), 32'(exp_col));
      @(negedge clk);
    end
    check("scan_no_valid", 32'(valid_count), 32'd0);
    check("scan_no_held", 32'(key_held), 32'h0);

    // Press '6' (row 1, column 2) for 30 cycles, then release
    apply_reset();
    press(2'd1, 2'd2);
    repeat (30) @(negedge clk);
    check("six_held", 32'(key_held), 32'h1);
    check("six_count", 32'(valid_count), 32'd1);
    check("six_code", 32'(key_code), 32'h6);
    check("six_right", 32'(right_digit), 32'h6);
    check("six_left", 32'(left_digit), 32'h0);
    pressed = 1'b0;
    // Two synchronizer edges, the HELD cycle seeing the release, then DB RELEASE cycles
    repeat (2 + DB) @(negedge clk);
    check("six_held_in_release", 32'(key_held), 32'h1);
    @(negedge clk);
    check("six_held_fall", 32'(key_held), 32'h0);
    check("six_col_advanced", 32'(col_n), 32'(4'b0111));
    check("six_single_valid", 32'(valid_count), 32'd1);

    // Press '0' (row 3, column 1) after '6'
    press(2'd3, 2'd1);
    wait_count(2, 100);
    repeat (3) @(negedge clk);
    pressed = 1'b0;
    wait_release(60);
    check("zero_count", 32'(valid_count), 32'd2);
    check("zero_code", 32'(key_code), 32'h0);
    check("zero_right", 32'(right_digit), 32'h0);
    check("zero_left", 32'(left_digit), 32'h6);
    check("zero_released", 32'(key_held), 32'h0);

    // Row 0 glitch around the column-0 sample
    apply_reset();
    pre = (GLITCH == 3) ? 0 : 1;
    repeat (pre) @(negedge clk);
    glitch_mask = 4'b0001;
    repeat (GLITCH) @(negedge clk);
    glitch_mask = 4'h0;
    repeat (8 - pre - GLITCH) @(negedge clk);
    check("glitch_col1", 32'(col_n), 32'(4'b1101));
    check("glitch_no_held", 32'(key_held), 32'h0);
    repeat (10) @(negedge clk);
    check("glitch_no_valid", 32'(valid_count), 32'd2);

    // Hold '5', bounce inside RELEASE, then release
    apply_reset();
    press(2'd1, 2'd1);
    wait_count(3, 100);
    repeat (4) @(negedge clk);
    check("five_held", 32'(key_held), 32'h1);
    pressed = 1'b0;
    repeat (BOUNCE) @(negedge clk);
    pressed = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("bounce_held", 32'(key_held), 32'h1);
    end
    check("bounce_no_repeat", 32'(valid_count), 32'd3);
    pressed = 1'b0;
    wait_release(60);
    check("five_released", 32'(key_held), 32'h0);
    check("five_single_valid", 32'(valid_count), 32'd3);
    check("five_code", 32'(key_code), 32'h5);
    check("five_left", 32'(left_digit), 32'h0);
    check("five_col_advanced", 32'(col_n), 32'(4'b1011));

    // Reset asserted mid-cycle while '7' is held
    apply_reset();
    press(2'd2, 2'd0);
    wait_count(4, 100);
    repeat (2) @(negedge clk);
    check("seven_code", 32'(key_code), 32'h7);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_col_n", 32'(col_n), 32'(4'b1110));
    check("async_key_held", 32'(key_held), 32'h0);
    check("async_key_code", 32'(key_code), 32'h0);
    check("async_key_valid", 32'(key_valid), 32'h0);
    check("async_left", 32'(left_digit), 32'h0);
    check("async_right", 32'(right_digit), 32'h0);
    pressed = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    press(2'd0, 2'd0);
    repeat (SHORT_PRESS) @(negedge clk);
    pressed = 1'b0;
    wait_count(5, 40);
    repeat (12) @(negedge clk);
    check("one_count", 32'(valid_count), 32'd5);
    check("one_code", 32'(key_code), 32'h1);
    check("one_right", 32'(right_digit), 32'h1);
    check("one_left", 32'(left_digit), 32'h0);
    check("one_released", 32'(key_held), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
